// File: rtl/dcache_ctrl.sv
// Blocking write-back data cache controller: single-cycle hits, line refill through
// MISS -> (WRITEBACK ->) READMISS -> FILL, then a re-lookup of the held request.
module dcache_ctrl (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         cpu_req_i,
    input  logic         cpu_we_i,
    input  logic [31:0]  cpu_addr_i,
    input  logic [31:0]  cpu_data_i,
    output logic [31:0]  cpu_data_o,
    output logic         cpu_stall_o,
    output logic [3:0]   sram_addr_o,
    output logic [24:0]  sram_tag_o,
    output logic [255:0] sram_data_o,
    output logic         sram_enable_o,
    output logic         sram_write_o,
    input  logic [24:0]  sram_tag_i,
    input  logic [255:0] sram_data_i,
    input  logic         sram_hit_i,
    output logic         mem_enable_o,
    output logic         mem_write_o,
    output logic [31:0]  mem_addr_o,
    output logic [255:0] mem_data_o,
    input  logic [255:0] mem_data_i,
    input  logic         mem_ack_i
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MISS,
        ST_WRITEBACK,
        ST_READMISS,
        ST_FILL
    } state_e;

    state_e         state_q, state_d;
    logic [22:0]    victim_tag_q, victim_tag_d;
    logic [255:0]   line_q, line_d;

    logic [22:0]    req_tag;
    logic [3:0]     req_index;
    logic [2:0]     req_word;
    logic [1:0]     unused_byte_offset;
    logic [255:0]   store_line;

    assign req_tag            = cpu_addr_i[31:9];
    assign req_index          = cpu_addr_i[8:5];
    assign req_word           = cpu_addr_i[4:2];
    assign unused_byte_offset = cpu_addr_i[1:0];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            victim_tag_q <= '0;
            line_q       <= '0;
        end else begin
            state_q      <= state_d;
            victim_tag_q <= victim_tag_d;
            line_q       <= line_d;
        end
    end

    // line_q holds the victim line until write-back completes, then the refill line.
    always_comb begin
        state_d      = state_q;
        victim_tag_d = victim_tag_q;
        line_d       = line_q;
        case (state_q)
            ST_IDLE: begin
                if (cpu_req_i && !sram_hit_i) begin
                    state_d = ST_MISS;
                end
            end
            ST_MISS: begin
                victim_tag_d = sram_tag_i[22:0];
                line_d       = sram_data_i;
                state_d      = (sram_tag_i[24] && sram_tag_i[23]) ? ST_WRITEBACK : ST_READMISS;
            end
            ST_WRITEBACK: begin
                if (mem_ack_i) begin
                    state_d = ST_READMISS;
                end
            end
            ST_READMISS: begin
                if (mem_ack_i) begin
                    line_d  = mem_data_i;
                    state_d = ST_FILL;
                end
            end
            ST_FILL: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        store_line                         = sram_data_i;
        store_line[{req_word, 5'b0} +: 32] = cpu_data_i;
    end

    // Enables are gated by rst_i so nothing is issued while reset is asserted.
    always_comb begin
        sram_addr_o   = req_index;
        sram_tag_o    = {2'b00, req_tag};
        sram_data_o   = '0;
        sram_enable_o = 1'b0;
        sram_write_o  = 1'b0;
        mem_enable_o  = 1'b0;
        mem_write_o   = 1'b0;
        mem_addr_o    = '0;
        mem_data_o    = '0;
        cpu_data_o    = '0;
        cpu_stall_o   = 1'b0;
        if (!rst_i) begin
            case (state_q)
                ST_IDLE: begin
                    if (cpu_req_i) begin
                        if (sram_hit_i) begin
                            cpu_data_o = sram_data_i[{req_word, 5'b0} +: 32];
                            if (cpu_we_i) begin
                                sram_enable_o = 1'b1;
                                sram_write_o  = 1'b1;
                                sram_tag_o    = {2'b11, req_tag};
                                sram_data_o   = store_line;
                            end
                        end else begin
                            cpu_stall_o = 1'b1;
                        end
                    end
                end
                ST_MISS: begin
                    cpu_stall_o = 1'b1;
                end
                ST_WRITEBACK: begin
                    cpu_stall_o  = 1'b1;
                    mem_enable_o = 1'b1;
                    mem_write_o  = 1'b1;
                    mem_addr_o   = {victim_tag_q, req_index, 5'b0};
                    mem_data_o   = line_q;
                end
                ST_READMISS: begin
                    cpu_stall_o  = 1'b1;
                    mem_enable_o = 1'b1;
                    mem_addr_o   = {req_tag, req_index, 5'b0};
                end
                ST_FILL: begin
                    cpu_stall_o   = 1'b1;
                    sram_enable_o = 1'b1;
                    sram_write_o  = 1'b1;
                    sram_tag_o    = {2'b10, req_tag};
                    sram_data_o   = line_q;
                end
                default: begin
                    cpu_stall_o = 1'b0;
                end
            endcase
        end
    end

    a_mem_implies_stall: assert property (@(posedge clk_i) disable iff (rst_i)
        mem_enable_o |-> cpu_stall_o);

endmodule

// File: tb/tb_dcache_ctrl.sv
// Randomized bench for dcache_ctrl: a direct-mapped SRAM and latency-programmable memory
// surround the DUT; a flat word-memory reference plus per-set residency model predicts results.
module tb_dcache_ctrl;

    logic         clk_i;
    logic         rst_i;
    logic         cpu_req_i;
    logic         cpu_we_i;
    logic [31:0]  cpu_addr_i;
    logic [31:0]  cpu_data_i;
    logic [31:0]  cpu_data_o;
    logic         cpu_stall_o;
    logic [3:0]   sram_addr_o;
    logic [24:0]  sram_tag_o;
    logic [255:0] sram_data_o;
    logic         sram_enable_o;
    logic         sram_write_o;
    logic [24:0]  sram_tag_i;
    logic [255:0] sram_data_i;
    logic         sram_hit_i;
    logic         mem_enable_o;
    logic         mem_write_o;
    logic [31:0]  mem_addr_o;
    logic [255:0] mem_data_o;
    logic [255:0] mem_data_i;
    logic         mem_ack_i;

    dcache_ctrl dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .cpu_req_i    (cpu_req_i),
        .cpu_we_i     (cpu_we_i),
        .cpu_addr_i   (cpu_addr_i),
        .cpu_data_i   (cpu_data_i),
        .cpu_data_o   (cpu_data_o),
        .cpu_stall_o  (cpu_stall_o),
        .sram_addr_o  (sram_addr_o),
        .sram_tag_o   (sram_tag_o),
        .sram_data_o  (sram_data_o),
        .sram_enable_o(sram_enable_o),
        .sram_write_o (sram_write_o),
        .sram_tag_i   (sram_tag_i),
        .sram_data_i  (sram_data_i),
        .sram_hit_i   (sram_hit_i),
        .mem_enable_o (mem_enable_o),
        .mem_write_o  (mem_write_o),
        .mem_addr_o   (mem_addr_o),
        .mem_data_o   (mem_data_o),
        .mem_data_i   (mem_data_i),
        .mem_ack_i    (mem_ack_i)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Direct-mapped tag/data SRAM seen by the controller.
    logic [24:0]  s_tag  [16];
    logic [255:0] s_line [16];

    assign sram_tag_i  = s_tag[cpu_addr_i[8:5]];
    assign sram_data_i = s_line[cpu_addr_i[8:5]];
    assign sram_hit_i  = s_tag[cpu_addr_i[8:5]][24] &&
                         (s_tag[cpu_addr_i[8:5]][22:0] == cpu_addr_i[31:9]);

    // Reference: architectural word memory; backing store: what main memory really holds.
    logic [31:0] ref_mem [logic [31:0]];
    logic [31:0] bk_mem  [logic [31:0]];
    logic        m_valid [16];
    logic        m_dirty [16];
    logic [22:0] m_tag   [16];

    int unsigned n_checks;
    int unsigned n_fail;

    task automatic check_eq(input string tag, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return init_word(a);
    endfunction

    function automatic logic [31:0] bk_rd(input logic [31:0] a);
        if (bk_mem.exists(a)) return bk_mem[a];
        return init_word(a);
    endfunction

    function automatic logic [255:0] ref_line(input logic [31:0] la);
        logic [255:0] l;
        for (int unsigned w = 0; w < 8; w++) l[w*32 +: 32] = ref_rd({la[31:5], w[2:0], 2'b00});
        return l;
    endfunction

    function automatic logic [255:0] bk_line(input logic [31:0] la);
        logic [255:0] l;
        for (int unsigned w = 0; w < 8; w++) l[w*32 +: 32] = bk_rd({la[31:5], w[2:0], 2'b00});
        return l;
    endfunction

    task automatic check_quiet(input string tag);
        check_eq({tag, "_ctl"}, 256'({cpu_stall_o, sram_enable_o, sram_write_o, mem_enable_o, mem_write_o}), 256'(0));
        check_eq({tag, "_cpu_data"}, 256'(cpu_data_o), 256'(0));
        check_eq({tag, "_mem_addr"}, 256'(mem_addr_o), 256'(0));
        check_eq({tag, "_mem_data"}, mem_data_o, 256'(0));
    endtask

    task automatic idle_cycles(input int unsigned n, input logic spurious);
        cpu_req_i = 1'b0;
        repeat (n) begin
            @(negedge clk_i);
            if (spurious) begin
                mem_ack_i  = 1'b1;
                mem_data_i = {8{$urandom}};
            end
            check_quiet("idle");
            @(posedge clk_i);
            #1;
            mem_ack_i = 1'b0;
        end
    endtask

    task automatic do_access(input logic we, input logic [31:0] addr, input logic [31:0] data,
                             input int unsigned lat_wb, input int unsigned lat_rd,
                             output logic [31:0] wb_addr, output logic [31:0] rd_addr,
                             output logic [31:0] obs_data, output int unsigned stalls);
        logic [3:0]   idx;
        logic [22:0]  tag;
        logic [31:0]  la, vla, waddr, exp_load;
        logic         hit_e, dirty_e, done, wr_en;
        logic [255:0] pre_line, post_line, victim_line, wr_data;
        logic [3:0]   wr_idx;
        logic [24:0]  wr_tag;
        int unsigned  exp_stall, cnt, lat, cyc;

        idx       = addr[8:5];
        tag       = addr[31:9];
        la        = {addr[31:5], 5'b0};
        waddr     = {addr[31:2], 2'b00};
        hit_e     = m_valid[idx] && (m_tag[idx] == tag);
        dirty_e   = !hit_e && m_valid[idx] && m_dirty[idx];
        vla       = {m_tag[idx], idx, 5'b0};
        exp_stall = hit_e ? 0 : 3 + lat_rd + (dirty_e ? lat_wb : 0);
        exp_load  = ref_rd(waddr);
        pre_line  = ref_line(la);
        victim_line = ref_line(vla);
        if (we) ref_mem[waddr] = data;
        post_line = ref_line(la);

        wb_addr = '0; rd_addr = '0; obs_data = '0; stalls = 0;
        cnt = 0; lat = 0; cyc = 0; done = 1'b0;
        cpu_req_i = 1'b1; cpu_we_i = we; cpu_addr_i = addr; cpu_data_i = data;

        while (!done && cyc < 200) begin
            @(negedge clk_i);
            cyc++;
            check_eq("sram_index_tag", 256'({sram_addr_o, sram_tag_o[22:0]}), 256'({idx, tag}));
            if (!cpu_stall_o) begin
                done     = 1'b1;
                obs_data = cpu_data_o;
                check_eq("stall_cycles", 256'(stalls), 256'(exp_stall));
                check_eq("hit_mem_idle", 256'({mem_enable_o, mem_write_o}), 256'(0));
                if (!we) begin
                    check_eq("load_data", 256'(cpu_data_o), 256'(exp_load));
                    check_eq("load_no_write", 256'({sram_enable_o, sram_write_o}), 256'(0));
                end else begin
                    check_eq("store_ctl", 256'({sram_enable_o, sram_write_o, sram_tag_o[24:23]}), 256'(4'b1111));
                    check_eq("store_line", sram_data_o, post_line);
                end
            end else begin
                stalls++;
                if (mem_enable_o) begin
                    if (mem_write_o) begin
                        lat = lat_wb;
                        if (cnt == 0) begin
                            wb_addr = mem_addr_o;
                            check_eq("wb_expected", 256'(dirty_e), 256'(1));
                            check_eq("wb_addr", 256'(mem_addr_o), 256'(vla));
                            check_eq("wb_data", mem_data_o, victim_line);
                        end else begin
                            check_eq("wb_addr_hold", 256'(mem_addr_o), 256'(wb_addr));
                        end
                    end else begin
                        lat = lat_rd;
                        if (cnt == 0) begin
                            rd_addr = mem_addr_o;
                            check_eq("rd_addr", 256'(mem_addr_o), 256'(la));
                        end else begin
                            check_eq("rd_addr_hold", 256'(mem_addr_o), 256'(rd_addr));
                        end
                        check_eq("rd_data_zero", mem_data_o, 256'(0));
                    end
                    cnt++;
                    if (cnt >= lat) begin
                        mem_ack_i = 1'b1;
                        if (mem_write_o) begin
                            for (int unsigned w = 0; w < 8; w++)
                                bk_mem[{mem_addr_o[31:5], w[2:0], 2'b00}] = mem_data_o[w*32 +: 32];
                        end else begin
                            mem_data_i = bk_line(mem_addr_o);
                        end
                        cnt = 0;
                    end
                end
                if (sram_write_o) begin
                    check_eq("fill_ctl", 256'({sram_enable_o, sram_tag_o[24:23]}), 256'(3'b110));
                    check_eq("fill_line", sram_data_o, pre_line);
                end
            end
            wr_en   = sram_enable_o && sram_write_o;
            wr_idx  = sram_addr_o;
            wr_tag  = sram_tag_o;
            wr_data = sram_data_o;
            @(posedge clk_i);
            #1;
            if (wr_en) begin
                s_tag[wr_idx]  = wr_tag;
                s_line[wr_idx] = wr_data;
            end
            mem_ack_i  = 1'b0;
            mem_data_i = {8{$urandom}};
        end
        check_eq("access_done", 256'(done), 256'(1));
        cpu_req_i    = 1'b0;
        m_dirty[idx] = hit_e ? (m_dirty[idx] | we) : we;
        m_valid[idx] = 1'b1;
        m_tag[idx]   = tag;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] wb, rd, obs, addr;
        int unsigned stalls, rm_seen;

        n_checks = 0;
        n_fail   = 0;
        for (int unsigned i = 0; i < 16; i++) begin
            s_tag[i] = '0; s_line[i] = '0;
            m_valid[i] = 1'b0; m_dirty[i] = 1'b0; m_tag[i] = '0;
        end
        ref_mem[32'h24] = 32'hDEAD_BEEF;
        bk_mem[32'h24]  = 32'hDEAD_BEEF;
        rst_i = 1'b1; cpu_req_i = 1'b0; cpu_we_i = 1'b0; cpu_addr_i = '0; cpu_data_i = '0;
        mem_ack_i = 1'b0; mem_data_i = '0;

        repeat (2) begin
            @(negedge clk_i);
            check_quiet("reset");
        end
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        idle_cycles(2, 1'b0);

        // Cold load, then single-cycle store into the now-resident line.
        do_access(1'b0, 32'h0000_0024, 32'h0, 1, 2, wb, rd, obs, stalls);
        check_eq("cold_rd_addr", 256'(rd), 256'(32'h0000_0020));
        check_eq("cold_load_data", 256'(obs), 256'(32'hDEAD_BEEF));
        do_access(1'b1, 32'h0000_0028, 32'h1234_5678, 1, 1, wb, rd, obs, stalls);
        check_eq("store_hit_stalls", 256'(stalls), 256'(0));

        // Make set 1 hold dirty tag 0x5, then miss to tag 0x7 in the same set.
        do_access(1'b1, 32'h0000_0A20, 32'hCAFE_0001, 2, 3, wb, rd, obs, stalls);
        check_eq("evict0_wb_addr", 256'(wb), 256'(32'h0000_0020));
        do_access(1'b0, 32'h0000_0E24, 32'h0, 3, 2, wb, rd, obs, stalls);
        check_eq("dirty_wb_addr", 256'(wb), 256'(32'h0000_0A20));
        check_eq("dirty_rd_addr", 256'(rd), 256'(32'h0000_0E20));
        check_eq("dirty_stalls", 256'(stalls), 256'(3 + 2 + 3));

        do_access(1'b0, 32'h0000_0064, 32'h0, 1, 10, wb, rd, obs, stalls);
        check_eq("slow_ack_stalls", 256'(stalls), 256'(13));

        // Reset in the middle of a refill, then a stray acknowledge.
        cpu_req_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h0000_1040; cpu_data_i = '0;
        rm_seen = 0;
        for (int unsigned c = 0; c < 20 && rm_seen < 3; c++) begin
            @(negedge clk_i);
            if (mem_enable_o && !mem_write_o) rm_seen++;
            if (rm_seen < 3) begin
                @(posedge clk_i);
                #1;
            end
        end
        check_eq("mid_refill_reached", 256'(rm_seen), 256'(3));
        rst_i = 1'b1;
        cpu_req_i = 1'b0;
        #1;
        check_quiet("during_reset");
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        @(negedge clk_i);
        check_quiet("after_reset");
        mem_ack_i  = 1'b1;
        mem_data_i = {8{$urandom}};
        @(posedge clk_i);
        #1;
        mem_ack_i = 1'b0;
        @(negedge clk_i);
        check_quiet("stray_ack");
        @(posedge clk_i);
        #1;

        idle_cycles(3, 1'b1);
        do_access(1'b0, 32'h0000_1040, 32'h0, 1, 2, wb, rd, obs, stalls);
        check_eq("post_reset_stalls", 256'(stalls), 256'(3 + 2));

        for (int unsigned n = 0; n < 250; n++) begin
            addr = ($urandom_range(0, 3) << 9) | ($urandom_range(0, 3) << 5) |
                   ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
            do_access(1'($urandom_range(0, 1)), addr, $urandom,
                      $urandom_range(1, 4), $urandom_range(1, 4), wb, rd, obs, stalls);
            if ($urandom_range(0, 3) == 0) idle_cycles($urandom_range(1, 2), 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
